// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, instruction classes.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  localparam logic [6:0] OPC_LW   = 7'd3;
  localparam logic [6:0] OPC_ADDI = 7'd19;
  localparam logic [6:0] OPC_SW   = 7'd35;
  localparam logic [6:0] OPC_ADD  = 7'd51;
  localparam logic [6:0] OPC_BNE  = 7'd99;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_I,
    CLS_ALU_R,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier; zero latency, no flow control.
module op_decoder
  import cpu_pkg::*;
#(
  parameter int OP_WIDTH = 7
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output op_class_t           op_class
);

  logic [31:0] op_ext;

  // Widen to 32 bits so any OP_WIDTH compares against the 7-bit constants with upper bits zero.
  always_comb begin
    op_ext   = 32'(opcode);
    op_class = CLS_ILLEGAL;
    if      (op_ext == 32'(OPC_ADDI)) op_class = CLS_ALU_I;
    else if (op_ext == 32'(OPC_ADD))  op_class = CLS_ALU_R;
    else if (op_ext == 32'(OPC_LW))   op_class = CLS_LOAD;
    else if (op_ext == 32'(OPC_SW))   op_class = CLS_STORE;
    else if (op_ext == 32'(OPC_BNE))  op_class = CLS_BRANCH;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: bne 3 cycles, addi/add/sw 4, lw 5 with same-cycle acks.
// FETCH and MEM hold their request until the matching ack; strobes are forced low during reset.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int OP_WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                EQ,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic                pc_src,
  output logic                reg_we,
  output logic                alu_src,
  output logic                alu_ctrl,
  output logic [1:0]          imm_src,
  output logic                wb_sel,
  output logic                illegal,
  output logic [31:0]         retire_cnt
);

  state_t    state, state_nxt;
  op_class_t dec_cls, cls_q;
  logic      set_illegal;
  logic      retire_inc;
  logic [31:0] retire_q;

  op_decoder #(.OP_WIDTH(OP_WIDTH)) u_dec (
    .opcode   (opcode),
    .op_class (dec_cls)
  );

  // Class is captured in DECODE so later states do not depend on the IR staying stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      cls_q    <= CLS_ALU_I;
      illegal  <= 1'b0;
      retire_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) cls_q <= dec_cls;
      if (set_illegal) illegal <= 1'b1;
      if (retire_inc) retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    reg_we      = 1'b0;
    alu_src     = 1'b0;
    alu_ctrl    = ALU_ADD;
    imm_src     = IMM_I;
    wb_sel      = 1'b0;

    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_cls == CLS_ILLEGAL) begin
          set_illegal = 1'b1;
          state_nxt   = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_ALU_I: begin
            alu_src   = 1'b1;
            state_nxt = S_WB;
          end
          CLS_ALU_R: state_nxt = S_WB;
          CLS_LOAD: begin
            alu_src   = 1'b1;
            state_nxt = S_MEM;
          end
          CLS_STORE: begin
            alu_src   = 1'b1;
            imm_src   = IMM_S;
            state_nxt = S_MEM;
          end
          CLS_BRANCH: begin
            alu_ctrl  = ALU_SUB;
            imm_src   = IMM_B;
            pc_we     = ~EQ;
            pc_src    = ~EQ;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ack) state_nxt = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (cls_q == CLS_LOAD);
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase

    retire_inc = (state == S_EXEC || state == S_MEM || state == S_WB) && (state_nxt == S_FETCH);

    // Reset gates strobes immediately so an in-flight access drops without waiting for a clock.
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      reg_we   = 1'b0;
      alu_src  = 1'b0;
      alu_ctrl = 1'b0;
      imm_src  = 2'b00;
      wb_sel   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; one step per clock, outputs sampled 1ns after the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        eq;
  logic        imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we;
  logic        alu_src, alu_ctrl, wb_sel, illegal;
  logic [1:0]  imm_src;
  logic [31:0] retire_cnt;
  logic [12:0] outs;
  int          total = 0;
  int          bad   = 0;

  multicycle_ctrl #(.OP_WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .EQ(eq),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
    .wb_sel(wb_sel), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Bit order: imem dmem dwe irwe pcwe pcsrc regwe alusrc aluctrl imm[1:0] wbsel illegal
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
                 alu_src, alu_ctrl, imm_src, wb_sel, illegal};

  localparam logic [12:0] V_ZERO   = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] V_FWAIT  = 13'b1_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] V_FACK   = 13'b1_0_0_1_1_0_0_0_0_00_0_0;
  localparam logic [12:0] V_EX_I   = 13'b0_0_0_0_0_0_0_1_0_00_0_0;
  localparam logic [12:0] V_EX_S   = 13'b0_0_0_0_0_0_0_1_0_01_0_0;
  localparam logic [12:0] V_BNE_T  = 13'b0_0_0_0_1_1_0_0_1_10_0_0;
  localparam logic [12:0] V_BNE_NT = 13'b0_0_0_0_0_0_0_0_1_10_0_0;
  localparam logic [12:0] V_MEM_LW = 13'b0_1_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] V_MEM_SW = 13'b0_1_1_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] V_WB_ALU = 13'b0_0_0_0_0_0_1_0_0_00_0_0;
  localparam logic [12:0] V_WB_LW  = 13'b0_0_0_0_0_0_1_0_0_00_1_0;
  localparam logic [12:0] V_HALT   = 13'b0_0_0_0_0_0_0_0_0_00_0_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic ia, input logic da, input logic e,
                      input logic [12:0] exp);
    @(negedge clk);
    imem_ack = ia;
    dmem_ack = da;
    eq       = e;
    #1;
    chk(tag, 32'(outs), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'd0; eq = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;

    // Reset: everything low even with acks asserted
    @(negedge clk); #1;
    chk("rst_outs", 32'(outs), 32'(V_ZERO));
    chk("rst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("first_imem_req", 32'(outs), 32'(V_FWAIT));

    // sw aborted by reset while waiting in MEM
    opcode = 7'd35;
    step("sw_ab_fetch", 1, 0, 0, V_FACK);
    step("sw_ab_dec",   0, 0, 0, V_ZERO);
    step("sw_ab_exec",  0, 0, 0, V_EX_S);
    step("sw_ab_mem",   0, 0, 0, V_MEM_SW);
    #1 rst_n = 1'b0;
    #1;
    chk("sw_ab_async_drop", 32'(outs), 32'(V_ZERO));
    chk("sw_ab_cnt", retire_cnt, 32'd0);
    @(negedge clk); #1;
    chk("sw_ab_held", 32'(outs), 32'(V_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sw_ab_restart", 32'(outs), 32'(V_FWAIT));

    // addi, same-cycle ack: ir_we cycle 1, reg_we cycle 4, count 0->1
    opcode = 7'd19;
    step("addi_c1", 1, 0, 0, V_FACK);
    step("addi_c2", 1, 1, 0, V_ZERO);   // stray acks outside FETCH/MEM ignored
    step("addi_c3", 0, 1, 0, V_EX_I);
    step("addi_c4", 0, 0, 0, V_WB_ALU);
    step("addi_done", 0, 0, 0, V_FWAIT);
    chk("addi_cnt", retire_cnt, 32'd1);

    // bne taken then not taken, 3 cycles each
    opcode = 7'd99;
    step("bne_t_c1", 1, 0, 0, V_FACK);
    step("bne_t_c2", 0, 0, 0, V_ZERO);
    step("bne_t_c3", 0, 0, 0, V_BNE_T);
    step("bne_t_done", 0, 0, 0, V_FWAIT);
    chk("bne_t_cnt", retire_cnt, 32'd2);
    step("bne_n_c1", 1, 0, 1, V_FACK);
    step("bne_n_c2", 0, 0, 1, V_ZERO);
    step("bne_n_c3", 0, 0, 1, V_BNE_NT);
    step("bne_n_done", 0, 0, 0, V_FWAIT);
    chk("bne_n_cnt", retire_cnt, 32'd3);

    // add
    opcode = 7'd51;
    step("add_c1", 1, 0, 0, V_FACK);
    step("add_c2", 0, 0, 0, V_ZERO);
    step("add_c3", 0, 0, 0, V_ZERO);
    step("add_c4", 0, 0, 0, V_WB_ALU);
    step("add_done", 0, 0, 0, V_FWAIT);
    chk("add_cnt", retire_cnt, 32'd4);

    // lw with dmem_ack three cycles late: dmem_req for 4 cycles
    opcode = 7'd3;
    step("lw_c1", 1, 0, 0, V_FACK);
    step("lw_c2", 0, 0, 0, V_ZERO);
    step("lw_c3", 0, 0, 0, V_EX_I);
    step("lw_m1", 0, 0, 0, V_MEM_LW);
    step("lw_m2", 0, 0, 0, V_MEM_LW);
    step("lw_m3", 0, 0, 0, V_MEM_LW);
    step("lw_m4", 0, 1, 0, V_MEM_LW);
    step("lw_wb", 0, 0, 0, V_WB_LW);
    step("lw_done", 0, 0, 0, V_FWAIT);
    chk("lw_cnt", retire_cnt, 32'd5);

    // sw, one fetch wait cycle first
    opcode = 7'd35;
    step("sw_fwait", 0, 0, 0, V_FWAIT);
    step("sw_c1", 1, 0, 0, V_FACK);
    step("sw_c2", 0, 0, 0, V_ZERO);
    step("sw_c3", 0, 0, 0, V_EX_S);
    step("sw_c4", 0, 1, 0, V_MEM_SW);
    step("sw_done", 0, 0, 0, V_FWAIT);
    chk("sw_cnt", retire_cnt, 32'd6);

    // Counter wrap
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    opcode = 7'd19;
    step("wrap_c1", 1, 0, 0, V_FACK);
    step("wrap_c2", 0, 0, 0, V_ZERO);
    step("wrap_c3", 0, 0, 0, V_EX_I);
    step("wrap_c4", 0, 0, 0, V_WB_ALU);
    step("wrap_done", 0, 0, 0, V_FWAIT);
    chk("wrap_cnt", retire_cnt, 32'd0);

    // Illegal opcode halts; later acks ignored; reset clears the flag
    opcode = 7'd127;
    step("ill_c1", 1, 0, 0, V_FACK);
    step("ill_c2", 0, 0, 0, V_ZERO);
    step("ill_halt", 0, 0, 0, V_HALT);
    step("ill_ack1", 1, 1, 0, V_HALT);
    step("ill_ack2", 1, 1, 0, V_HALT);
    step("ill_ack3", 0, 0, 0, V_HALT);
    chk("ill_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ill_rst", 32'(outs), 32'(V_ZERO));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ill_restart", 32'(outs), 32'(V_FWAIT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
